// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_counter_multi_if.sv
// Control/status bundle between the register side and the multi-channel timer.
interface timer_counter_multi_if #(
  parameter int N  = 32,
  parameter int CH = 4,
  parameter int PW = 8
);
  logic [PW-1:0]   prescale;
  logic [CH-1:0]   enable;
  logic [CH-1:0]   mode;
  logic [CH-1:0]   load;
  logic [CH*N-1:0] final_value;
  logic [CH-1:0]   clear_flag;
  logic [CH*N-1:0] count;
  logic [CH-1:0]   done;
  logic [CH-1:0]   flag;
  logic [CH-1:0]   running;

  modport master (
    output prescale, enable, mode, load, final_value, clear_flag,
    input  count, done, flag, running
  );

  modport slave (
    input  prescale, enable, mode, load, final_value, clear_flag,
    output count, done, flag, running
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/HALT FSM with count, registered done pulse and sticky flag.
//   state | meaning
//   IDLE  | after reset, count holds, waits for load
//   RUN   | counting on enabled ticks
//   HALT  | one-shot expired, count holds, waits for load
module timer_channel
  import timer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_tick,
  input  logic         i_enable,
  input  logic         i_mode,
  input  logic         i_load,
  input  logic [N-1:0] i_final_value,
  input  logic         i_clear_flag,
  output logic [N-1:0] o_count,
  output logic         o_done,
  output logic         o_flag,
  output logic         o_running
);

  state_e       r_state;
  logic [N-1:0] r_count;
  logic         r_done;
  logic         r_flag;
  logic         r_running;
  logic         w_terminal;

  // >= compare so a lowered final_value terminates on the next tick instead of wrapping
  assign w_terminal = (r_state == RUN) && !i_load && i_enable && i_tick &&
                      (r_count >= i_final_value);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_done    <= 1'b0;
      r_flag    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_done <= w_terminal;
      if (w_terminal) begin
        r_flag <= 1'b1;
      end else if (i_clear_flag) begin
        r_flag <= 1'b0;
      end

      case (r_state)
        IDLE, HALT: begin
          if (i_load) begin
            r_state   <= RUN;
            r_count   <= '0;
            r_running <= 1'b1;
          end
        end
        RUN: begin
          if (i_load) begin
            r_count <= '0;
          end else if (w_terminal) begin
            if (i_mode == MODE_ONESHOT) begin
              r_state   <= HALT;
              r_running <= 1'b0;
            end else begin
              r_count <= '0;
            end
          end else if (i_enable && i_tick) begin
            r_count <= r_count + N'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_count   = r_count;
  assign o_done    = r_done;
  assign o_flag    = r_flag;
  assign o_running = r_running;

endmodule

// File: rtl/timer_counter_multi.sv
// Multi-channel timer: one shared free-running prescaler feeding CH independent channels.
module timer_counter_multi
  import timer_pkg::*;
#(
  parameter int N  = 32,
  parameter int CH = 4,
  parameter int PW = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_counter_multi_if.slave  bus
);

  logic [PW-1:0] r_pre_cnt;
  logic          w_tick;
  logic [N-1:0]  w_count [CH];
  logic [CH-1:0] w_done;
  logic [CH-1:0] w_flag;
  logic [CH-1:0] w_running;

  // >= lets a lowered prescale wrap immediately rather than running out to 2^PW
  assign w_tick = (r_pre_cnt >= bus.prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PW'(1);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    timer_channel #(.N(N)) u_ch (
      .clk           (clk),
      .rst           (reset),
      .i_tick        (w_tick),
      .i_enable      (bus.enable[g]),
      .i_mode        (bus.mode[g]),
      .i_load        (bus.load[g]),
      .i_final_value (bus.final_value[g*N +: N]),
      .i_clear_flag  (bus.clear_flag[g]),
      .o_count       (w_count[g]),
      .o_done        (w_done[g]),
      .o_flag        (w_flag[g]),
      .o_running     (w_running[g])
    );
  end

  always_comb begin
    bus.count = '0;
    for (int i = 0; i < CH; i++) begin
      bus.count[i*N +: N] = w_count[i];
    end
  end

  assign bus.done    = w_done;
  assign bus.flag    = w_flag;
  assign bus.running = w_running;

endmodule

// File: tb/tb_timer_counter_multi.sv
// Bench for timer_counter_multi: directed scenarios plus random traffic against a behavioural model.
module tb_timer_counter_multi;
  localparam int N  = 32;
  localparam int CH = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  timer_counter_multi_if #(.N(N), .CH(CH), .PW(PW)) bus();

  timer_counter_multi #(.N(N), .CH(CH), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // model: prescaler phase and per-channel view of what the outputs must be
  int           m_pre;
  bit           m_run  [CH];
  bit [N-1:0]   m_cnt  [CH];
  bit           m_done [CH];
  bit           m_flag [CH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_cnt[c] = '0; m_done[c] = 0; m_flag[c] = 0;
    end
  endtask

  task automatic model_step();
    bit tick;
    bit set;
    bit [N-1:0] fv;
    tick  = (m_pre >= int'(bus.prescale));
    m_pre = tick ? 0 : m_pre + 1;
    for (int c = 0; c < CH; c++) begin
      fv = bus.final_value[c*N +: N];
      set = 0;
      m_done[c] = 0;
      if (!m_run[c]) begin
        if (bus.load[c]) begin m_run[c] = 1; m_cnt[c] = '0; end
      end else if (bus.load[c]) begin
        m_cnt[c] = '0;
      end else if (bus.enable[c] && tick) begin
        if (m_cnt[c] >= fv) begin
          m_done[c] = 1; set = 1;
          if (bus.mode[c]) m_run[c] = 0;
          else m_cnt[c] = '0;
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
        end
      end
      if (set) m_flag[c] = 1;
      else if (bus.clear_flag[c]) m_flag[c] = 0;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("count[%0d]", c),   64'(bus.count[c*N +: N]), 64'(m_cnt[c]));
      chk($sformatf("done[%0d]", c),    64'(bus.done[c]),    64'(m_done[c]));
      chk($sformatf("flag[%0d]", c),    64'(bus.flag[c]),    64'(m_flag[c]));
      chk($sformatf("running[%0d]", c), 64'(bus.running[c]), 64'(m_run[c]));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [N-1:0] cnt_of(input int c);
    return bus.count[c*N +: N];
  endfunction

  int exp_a_cnt  [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int exp_a_done [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    bus.prescale = '0; bus.enable = '0; bus.mode = '0; bus.load = '0;
    bus.final_value = '0; bus.clear_flag = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("rst_count[%0d]", c), 64'(cnt_of(c)), 64'd0);
      chk($sformatf("rst_run[%0d]", c), 64'(bus.running[c]), 64'd0);
    end
    chk("rst_done_flag", 64'({bus.done, bus.flag}), 64'd0);
    reset = 1'b0;

    // periodic F=3 on ch0, prescale 0
    bus.enable = '1;
    bus.final_value[0*N +: N] = 3;
    bus.load[0] = 1'b1;
    step();
    bus.load = '0;
    chk("a_load_count", 64'(cnt_of(0)), 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("a_count_%0d", i), 64'(cnt_of(0)), 64'(exp_a_cnt[i]));
      chk($sformatf("a_done_%0d", i), 64'(bus.done[0]), 64'(exp_a_done[i]));
      if (i == 3) chk("a_flag_set", 64'(bus.flag[0]), 64'd1);
    end
    bus.clear_flag[0] = 1'b1;
    step();
    bus.clear_flag = '0;
    chk("a_flag_clr", 64'(bus.flag[0]), 64'd0);

    // one-shot F=2 on ch1, prescale 2
    bus.prescale = 2;
    bus.mode[1] = 1'b1;
    bus.final_value[1*N +: N] = 2;
    bus.load[1] = 1'b1;
    step();
    bus.load = '0;
    repeat (30) step();
    chk("b_running", 64'(bus.running[1]), 64'd0);
    chk("b_hold", 64'(cnt_of(1)), 64'd2);
    chk("b_flag", 64'(bus.flag[1]), 64'd1);
    bus.load[1] = 1'b1;
    step();
    bus.load = '0;
    chk("b_reload_count", 64'(cnt_of(1)), 64'd0);
    chk("b_reload_run", 64'(bus.running[1]), 64'd1);

    // lowered final_value on ch2
    bus.prescale = 0;
    bus.final_value[2*N +: N] = 20;
    bus.load[2] = 1'b1;
    step();
    bus.load = '0;
    repeat (10) step();
    chk("c_count10", 64'(cnt_of(2)), 64'd10);
    bus.final_value[2*N +: N] = 5;
    step();
    chk("c_done", 64'(bus.done[2]), 64'd1);
    chk("c_count0", 64'(cnt_of(2)), 64'd0);

    // terminal tick coincident with clear_flag, then restart mid-run on ch3
    bus.final_value[3*N +: N] = 2;
    bus.load[3] = 1'b1;
    step();
    bus.load = '0;
    step(); step();
    bus.clear_flag[3] = 1'b1;
    step();
    bus.clear_flag = '0;
    chk("d_done", 64'(bus.done[3]), 64'd1);
    chk("d_flag_set_wins", 64'(bus.flag[3]), 64'd1);
    bus.final_value[3*N +: N] = 20;
    bus.load[3] = 1'b1;
    step();
    bus.load = '0;
    repeat (7) step();
    chk("d_count7", 64'(cnt_of(3)), 64'd7);
    bus.load[3] = 1'b1;
    step();
    bus.load = '0;
    chk("d_restart_count", 64'(cnt_of(3)), 64'd0);
    chk("d_restart_done", 64'(bus.done[3]), 64'd0);

    // all channels F=0 periodic
    bus.mode = '0;
    bus.final_value = '0;
    bus.load = '1;
    step();
    bus.load = '0;
    repeat (3) begin
      step();
      chk("e_done_all", 64'(bus.done), 64'({CH{1'b1}}));
    end
    bus.enable = '0;
    repeat (5) begin
      step();
      chk("e_done_off", 64'(bus.done), 64'd0);
      chk("e_count_frozen", 64'(cnt_of(1)), 64'd0);
    end
    bus.enable = '1;

    // asynchronous reset between edges
    for (int c = 0; c < CH; c++) bus.final_value[c*N +: N] = 50;
    bus.load = '1;
    step();
    bus.load = '0;
    repeat (10) step();
    chk("f_precount", 64'(cnt_of(0)), 64'd10);
    #3 reset = 1'b1;
    #1;
    for (int c = 0; c < CH; c++) chk($sformatf("f_async_count[%0d]", c), 64'(cnt_of(c)), 64'd0);
    chk("f_async_bits", 64'({bus.done, bus.flag, bus.running}), 64'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) begin
      step();
      chk("f_idle_count", 64'(cnt_of(2)), 64'd0);
    end

    // randomized traffic
    for (int c = 0; c < CH; c++) bus.final_value[c*N +: N] = N'($urandom_range(0, 12));
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) bus.prescale = PW'($urandom_range(0, 3));
      for (int c = 0; c < CH; c++) begin
        bus.enable[c]     = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 49) == 0) bus.mode[c] = 1'($urandom_range(0, 1));
        bus.load[c]       = ($urandom_range(0, 19) == 0);
        bus.clear_flag[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 29) == 0) bus.final_value[c*N +: N] = N'($urandom_range(0, 12));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_counter_multi.md
Name: timer_counter_multi

Overview:
Multi-channel programmable timer, the parametrised successor to the single-channel timer counter.
- CH independent up-counters of width N share one programmable prescaler.
- Each channel runs in periodic or one-shot mode and has explicit start (load), a registered done pulse, and a sticky, software-clearable flag.
- Sits between the control/register interface and peripherals that need periodic ticks or timeouts.

Parameters:
N, 32, counter and final_value width per channel
CH, 4, number of channels
PW, 8, prescaler width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
prescale  in  PW  tick divider; a tick every prescale+1 cycles
enable  in  CH  per-channel count enable
mode  in  CH  per-channel mode: 0 = periodic, 1 = one-shot
load  in  CH  per-channel start/restart pulse
final_value  in  CH*N  per-channel terminal value; channel i uses bits [i*N +: N]
clear_flag  in  CH  per-channel flag clear pulse
count  out  CH*N  current count per channel
done  out  CH  one-cycle terminal pulse, registered
flag  out  CH  sticky terminal indication
running  out  CH  1 while channel is in RUN

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high; it may assert mid-operation.
- Reset values: prescaler count 0; every channel in IDLE with count = 0, done = 0, flag = 0, running = 0.
- Prescaler:
  - Free-running, shared, independent of enable and load.
  - When pre_cnt == prescale: tick = 1 and pre_cnt <= 0; otherwise pre_cnt <= pre_cnt + 1.
  - prescale = 0 gives a tick every cycle.
  - If prescale is lowered below pre_cnt, the >= compare forces a tick and wrap on the next cycle (no 2^PW wrap).
- Channel FSM states: IDLE, RUN, HALT.
  - IDLE: count holds. load -> RUN, count <= 0.
  - RUN, load = 1: count <= 0 and stay in RUN (restart). load has priority over the tick.
  - RUN, enable & tick, not terminal: count <= count + 1.
  - RUN, enable & tick, terminal (count >= final_value):
    - done <= 1 for exactly one cycle; flag <= 1.
    - Periodic: count <= 0, stay in RUN.
    - One-shot: go to HALT, count holds its value.
  - RUN, enable = 0 or no tick: count holds, with no lost or extra counts.
  - HALT: count holds and enable is ignored. load -> RUN, count <= 0.
- Cycle-level timing (prescale = 0, enable = 1):
  - load at edge t gives count = 0 after t.
  - Sequence is 0, 1, ..., F, then done is high in the cycle after count = F, coincident with count = 0 (periodic).
  - Period is F+1 ticks.
- Terminal compare uses >=. A final_value lowered below the current count terminates on the next tick, with no 2^N wrap.
- final_value = 0 in periodic mode: done on every tick.
- count never exceeds 2^N-1 and no overflow is possible.
- Flag:
  - clear_flag clears it.
  - Simultaneous set and clear: set wins.
  - Flag is unaffected by load.
- running = (state == RUN).
- Channels are fully independent apart from the shared tick.
- Simultaneous load and clear_flag on the same channel are both honoured.
- reset mid-count returns every channel to IDLE immediately (asynchronous). Counting resumes only after a new load.

Decomposition:
- Package timer_pkg:
  - state enum: IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2.
  - mode constants: MODE_PERIODIC = 1'b0, MODE_ONESHOT = 1'b1.
- Sub-module timer_channel (parameter N): one channel's FSM, count, done and flag. It takes tick as an input.
- The top holds the prescaler and a generate loop instantiating CH copies of timer_channel.

Test Plan:
- prescale = 0, ch0 periodic, F = 3, load, enable = 1 -> count 0,1,2,3,0,1...; done high every 4th cycle; flag set after the first done, cleared by clear_flag.
- prescale = 2, ch1 one-shot, F = 2 -> count advances every 3 cycles 0,1,2; one done pulse; running drops; count holds 2 for 20 cycles. A second load restarts from 0.
- ch2 running at count 10, final_value changed 20 -> 5 -> done on the next tick, count 0 (periodic).
- Simultaneous terminal tick and clear_flag on ch3 -> flag = 1. load during RUN at count 7 -> count 0 next cycle and no done.
- All channels, F = 0 periodic, prescale = 0 -> done high every cycle. enable toggled off for 5 cycles -> count frozen, done = 0.
- reset asserted mid-count (async, between edges) -> all outputs 0 immediately. After release with no load, counts stay 0.
